// File: rtl/fp_addconv_dispatch.sv
// rtl/fp_addconv_dispatch.sv - request FIFO, issue/hold sequencer and result capture around the FP adder/converter
module fp_addconv_dispatch #(
    parameter int size_mantissa        = 24,
    parameter int size_exponent        = 8,
    parameter int size_exception_field = 2,
    parameter int size                 = size_mantissa + size_exponent + size_exception_field,
    parameter int DEPTH                = 4,
    parameter int PTR_W                = 2,
    parameter int TAG_W                = 4,
    parameter int LATENCY              = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_conversion,
    input  logic              in_sub,
    input  logic [size-1:0]   in_a,
    input  logic [size-1:0]   in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [1:0]        add_conversion,
    output logic              add_sub,
    output logic [size-1:0]   add_a,
    output logic [size-1:0]   add_b,
    input  logic [size-1:0]   add_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [size-1:0]   out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_illegal
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [size-1:0]  ILLEGAL_RESULT = {2'b11, {(size - 2){1'b0}}};

    typedef struct packed {
        logic [1:0]       conv;
        logic             sub;
        logic [size-1:0]  a;
        logic [size-1:0]  b;
        logic [TAG_W-1:0] tag;
    } op_t;

    op_t              fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    op_t              op_q;
    logic [size-1:0]  out_result_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_illegal_q;

    op_t  head;
    logic push, pop, capture, head_illegal, nonempty;

    assign head         = fifo_q[rd_ptr_q];
    assign head_illegal = (head.conv == 2'b11);
    assign nonempty     = (count_q != '0);
    // Ready comes from the registered count only, so a same-cycle pop never re-opens a full FIFO.
    assign in_ready     = (count_q != FULL_CNT);
    assign push         = in_valid && in_ready;

    // Sequencer: pop from IDLE or on a HOLD handshake, count wait cycles in ISSUE.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        pop     = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (nonempty) pop = 1'b1;
            end
            ST_ISSUE: begin
                if (wait_q == LAT_CNT) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (nonempty) pop = 1'b1;
                    else          state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop) begin
            wait_d  = '0;
            state_d = head_illegal ? ST_HOLD : ST_ISSUE;
        end
    end

    // FIFO storage; entries need no reset because count gates their use.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= '{conv: in_conversion, sub: in_sub, a: in_a, b: in_b, tag: in_tag};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // State, wait counter, operation register and captured result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wait_q        <= '0;
            op_q          <= '0;
            out_result_q  <= '0;
            out_tag_q     <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (pop) begin
                op_q <= head;
                // Illegal requests never reach the adder; their response is formed here.
                if (head_illegal) begin
                    out_result_q  <= ILLEGAL_RESULT;
                    out_tag_q     <= head.tag;
                    out_illegal_q <= 1'b1;
                end
            end
            if (capture) begin
                out_result_q  <= add_result;
                out_tag_q     <= op_q.tag;
                out_illegal_q <= 1'b0;
            end
        end
    end

    // Operands reach the adder only while issuing and are zero otherwise.
    always_comb begin
        add_conversion = '0;
        add_sub        = 1'b0;
        add_a          = '0;
        add_b          = '0;
        if (state_q == ST_ISSUE) begin
            add_conversion = op_q.conv;
            add_sub        = op_q.sub;
            add_a          = op_q.a;
            add_b          = op_q.b;
        end
    end

    assign out_valid   = (state_q == ST_HOLD);
    assign out_result  = out_result_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_fp_addconv_dispatch.sv
// tb/tb_fp_addconv_dispatch.sv - scoreboard bench for fp_addconv_dispatch with adder stubs
module tb_fp_addconv_dispatch;

    localparam int SZ = 34;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in datapath: any deterministic function of the operands shows capture is unmodified.
    function automatic logic [SZ-1:0] stub_fn(input logic [1:0] c, input logic s,
                                              input logic [SZ-1:0] a, input logic [SZ-1:0] b);
        case (c)
            2'b00:   return s ? (a - b) : (a + b);
            2'b01:   return a ^ b;
            2'b10:   return ~a;
            default: return '0;
        endcase
    endfunction

    // DUT with combinational adder stub (LATENCY 0)
    logic          in_valid, in_ready, in_sub, out_valid, out_ready, out_illegal, add_sub;
    logic [1:0]    in_conversion, add_conversion;
    logic [SZ-1:0] in_a, in_b, add_a, add_b, add_result, out_result;
    logic [TW-1:0] in_tag, out_tag;

    assign add_result = stub_fn(add_conversion, add_sub, add_a, add_b);

    fp_addconv_dispatch dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_conversion(in_conversion), .in_sub(in_sub),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .add_conversion(add_conversion), .add_sub(add_sub), .add_a(add_a), .add_b(add_b),
        .add_result(add_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    // DUT with 3-cycle registered adder stub (LATENCY 3)
    logic          in2_valid, in2_ready, in2_sub, out2_valid, out2_ready, out2_illegal, add2_sub;
    logic [1:0]    in2_conversion, add2_conversion;
    logic [SZ-1:0] in2_a, in2_b, add2_a, add2_b, add2_result, out2_result;
    logic [TW-1:0] in2_tag, out2_tag;
    logic [SZ-1:0] p0, p1, p2;

    always @(posedge clk) begin
        p0 <= stub_fn(add2_conversion, add2_sub, add2_a, add2_b);
        p1 <= p0;
        p2 <= p1;
    end
    assign add2_result = p2;

    fp_addconv_dispatch #(.LATENCY(3)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in2_valid), .in_ready(in2_ready), .in_conversion(in2_conversion), .in_sub(in2_sub),
        .in_a(in2_a), .in_b(in2_b), .in_tag(in2_tag),
        .add_conversion(add2_conversion), .add_sub(add2_sub), .add_a(add2_a), .add_b(add2_b),
        .add_result(add2_result),
        .out_valid(out2_valid), .out_ready(out2_ready), .out_result(out2_result),
        .out_tag(out2_tag), .out_illegal(out2_illegal)
    );

    typedef struct {
        logic [SZ-1:0] res;
        logic [TW-1:0] tag;
        logic          ill;
    } exp_t;

    exp_t sbq[$];
    int   hs_cyc[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic rand_ready = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: what the stage must return for a request.
    function automatic exp_t model(input logic [1:0] c, input logic s, input logic [SZ-1:0] a,
                                   input logic [SZ-1:0] b, input logic [TW-1:0] tg);
        exp_t e;
        e.tag = tg;
        if (c == 2'b11) begin
            e.res = {2'b11, 32'h0};
            e.ill = 1'b1;
        end else begin
            e.res = stub_fn(c, s, a, b);
            e.ill = 1'b0;
        end
        return e;
    endfunction

    // Monitor: compares each handshake against the scoreboard head and checks stall stability.
    logic          prev_stall = 1'b0;
    logic [SZ-1:0] prev_res;
    logic [TW-1:0] prev_tag;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (out_valid) begin
                check("add_a_zero_in_hold", 64'(add_a), 64'd0);
                if (prev_stall) begin
                    check("stall_result_stable", 64'(out_result), 64'(prev_res));
                    check("stall_tag_stable", 64'(out_tag), 64'(prev_tag));
                end
                if (out_ready) begin
                    hs_cyc.push_back(cyc);
                    if (sbq.size() == 0) begin
                        check("unexpected_result", 64'(out_tag), 64'hffff);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        check("out_result", 64'(out_result), 64'(e.res));
                        check("out_tag", 64'(out_tag), 64'(e.tag));
                        check("out_illegal", 64'(out_illegal), 64'(e.ill));
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = out_result;
            prev_tag   = out_tag;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic s, input logic [SZ-1:0] a,
                        input logic [SZ-1:0] b, input logic [TW-1:0] tg, output int acc);
        int n = 0;
        in_valid = 1'b1; in_conversion = c; in_sub = s; in_a = a; in_b = b; in_tag = tg;
        while (!in_ready && n < 300) begin
            step();
            n++;
        end
        acc = cyc;
        if (!in_ready) begin
            check("send_timeout", 64'd0, 64'd1);
        end else begin
            sbq.push_back(model(c, s, a, b, tg));
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_hs(input int k);
        for (int n = 0; n < 200 && hs_cyc.size() < k; n++) step();
        check("hs_wait", 64'(hs_cyc.size() >= k), 64'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 600 && sbq.size() != 0; n++) step();
        check("drain_empty", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        int t;
        int issue_cycles;
        int first_v;
        logic [SZ-1:0] r2;
        logic [TW-1:0] g2;
        logic          i2;

        rst = 1'b1;
        in_valid = 1'b0; in_conversion = '0; in_sub = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
        out_ready = 1'b0;
        in2_valid = 1'b0; in2_conversion = '0; in2_sub = 1'b0; in2_a = '0; in2_b = '0; in2_tag = '0;
        out2_ready = 1'b1;
        step(); step();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_add_a", 64'(add_a), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        rst = 1'b0;
        step();

        // First legal op: out_valid three cycles after the push
        out_ready = 1'b1;
        hs_cyc.delete();
        send(2'b00, 1'b0, 34'h1_3F80_0000, 34'h1_3F80_0000, 4'd5, t);
        wait_hs(1);
        check("latency_legal", 64'(hs_cyc[0] - t), 64'd3);

        // Illegal op: out_valid two cycles after the push
        step(); step();
        hs_cyc.delete();
        send(2'b11, 1'b1, 34'h0_1234_5678, 34'h2_0000_0001, 4'd9, t);
        wait_hs(1);
        check("latency_illegal", 64'(hs_cyc[0] - t), 64'd2);

        // Backpressure: one in flight plus four queued fills the stage
        step(); step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send(2'($urandom_range(0, 2)), 1'($urandom), SZ'({$urandom, $urandom}),
                 SZ'({$urandom, $urandom}), TW'(i), t);
        check("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_tag = 4'd15;
        for (int i = 0; i < 3; i++) begin
            step();
            check("full_no_accept", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        step(); step();
        hs_cyc.delete();
        out_ready = 1'b1;
        wait_hs(5);
        for (int i = 1; i < 5; i++)
            check("drain_spacing", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd2);
        drain();

        // Simultaneous push and pop with three queued keeps the count at three
        step(); step();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(2'b01, 1'b0, SZ'({$urandom, $urandom}), SZ'({$urandom, $urandom}), TW'(10 + i), t);
        step(); step();
        check("pp_pre_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        send(2'b10, 1'b0, SZ'({$urandom, $urandom}), 34'h0, 4'd14, t);
        out_ready = 1'b0;
        check("pp_count_kept", 64'(in_ready), 64'd1);
        step();
        out_ready = 1'b1;
        drain();

        // LATENCY 3: operands held four ISSUE cycles, registered stub value captured
        step();
        in2_valid = 1'b1; in2_conversion = 2'b00; in2_sub = 1'b1;
        in2_a = 34'h1_3F80_0000; in2_b = 34'h0_0000_1234; in2_tag = 4'd6;
        t = cyc;
        check("l3_in_ready", 64'(in2_ready), 64'd1);
        step();
        in2_valid = 1'b0;
        issue_cycles = 0; first_v = -1; r2 = '0; g2 = '0; i2 = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (add2_a == 34'h1_3F80_0000) issue_cycles++;
            if (out2_valid && first_v < 0) begin
                first_v = cyc; r2 = out2_result; g2 = out2_tag; i2 = out2_illegal;
            end
            step();
        end
        check("l3_issue_cycles", 64'(issue_cycles), 64'd4);
        check("l3_latency", 64'(first_v - t), 64'd6);
        check("l3_result", 64'(r2), 64'(34'h1_3F80_0000 - 34'h0_0000_1234));
        check("l3_tag", 64'(g2), 64'd6);
        check("l3_illegal", 64'(i2), 64'd0);

        // Reset mid-operation discards everything in flight or queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(2'b00, 1'b0, SZ'({$urandom, $urandom}), SZ'({$urandom, $urandom}), TW'(1 + i), t);
        rst = 1'b1;
        step();
        sbq.delete();
        step();
        rst = 1'b0;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("mid_rst_no_valid", 64'(out_valid), 64'd0);
            step();
        end
        hs_cyc.delete();
        send(2'b01, 1'b0, 34'h2_AAAA_5555, 34'h1_0F0F_F0F0, 4'd7, t);
        wait_hs(1);
        drain();

        // Random traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send(2'($urandom_range(0, 3)), 1'($urandom), SZ'({$urandom, $urandom}),
                 SZ'({$urandom, $urandom}), TW'($urandom), t);
            if ($urandom_range(0, 3) == 0) step();
        end
        rand_ready = 1'b0;
        step();
        out_ready = 1'b1;
        drain();
        step(); step();
        check("final_idle", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
